// File: rtl/hamming_decoder.sv
// SEC Hamming(71,64) decoder: two-stage pipeline (syndrome, then correction) with saturating error counters.
// Latency 2 cycles; valid/ready on both sides, stage 2 holds while stalled, in_ready has no path from in_valid.
// Backpressure propagates one stage per cycle; full throughput when out_ready stays high.
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [64:1]      in_d,
  input  logic [6:0]       in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [64:1]      out_d,
  output logic [6:0]       out_syndrome,
  output logic             out_corr,
  output logic             out_uncorr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // Codeword position of each data bit: the non-power-of-two positions 3,5,6,7,9,... in order.
  function automatic logic [64:1][6:0] pos_table();
    logic [64:1][6:0] t;
    int k;
    t = '0;
    k = 1;
    for (int p = 1; p <= 71; p++) begin
      if ((p & (p - 1)) != 0) begin
        t[k] = 7'(p);
        k++;
      end
    end
    return t;
  endfunction

  localparam logic [64:1][6:0] POS = pos_table();

  logic             s1_valid_q, s1_valid_d;
  logic [64:1]      s1_data_q, s1_data_d;
  logic [6:0]       s1_syn_q, s1_syn_d;
  logic             out_valid_q, out_valid_d;
  logic [64:1]      out_data_q, out_data_d;
  logic [6:0]       out_syn_q, out_syn_d;
  logic             out_corr_q, out_corr_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic        s2_accept;
  logic        s1_load;
  logic        s1_adv;
  logic        out_fire;
  logic [6:0]  syn_calc;
  logic [64:1] fixed_data;
  logic        fix_uncorr;
  logic        fix_corr;

  assign s2_accept = !out_valid_q || out_ready;
  assign s1_adv    = s1_valid_q && s2_accept;
  // Gated by reset_n so nothing is accepted while reset is held.
  assign in_ready  = reset_n && (!s1_valid_q || s2_accept);
  assign s1_load   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

  // XOR of the positions of all set data bits, folded into the received check bits.
  always_comb begin
    syn_calc = in_p;
    for (int k = 1; k <= 64; k++) begin
      if (in_d[k]) syn_calc = syn_calc ^ POS[k];
    end
  end

  // Only data positions match POS, so check-bit errors and out-of-range syndromes leave data untouched.
  always_comb begin
    fixed_data = s1_data_q;
    for (int k = 1; k <= 64; k++) begin
      if (POS[k] == s1_syn_q) fixed_data[k] = ~s1_data_q[k];
    end
    fix_uncorr = (s1_syn_q > 7'd71);
    fix_corr   = (s1_syn_q != 7'd0) && !fix_uncorr;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_d;
      s1_syn_d   = syn_calc;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_corr_d   = out_corr_q;
    out_uncorr_d = out_uncorr_q;
    if (s1_adv) begin
      out_valid_d  = 1'b1;
      out_data_d   = fixed_data;
      out_syn_d    = s1_syn_q;
      out_corr_d   = fix_corr;
      out_uncorr_d = fix_uncorr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (out_fire && out_corr_q && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (out_fire && out_uncorr_q && (uncorr_cnt_q != '1))
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_corr_q   <= out_corr_d;
      out_uncorr_q <= out_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_d        = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_corr     = out_corr_q;
  assign out_uncorr   = out_uncorr_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder with 4-bit counters so saturation is reachable quickly.
module tb_hamming_decoder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [64:1] in_d;
  logic [6:0]  in_p;
  logic        out_valid;
  logic        out_ready;
  logic [64:1] out_d;
  logic [6:0]  out_syndrome;
  logic        out_corr;
  logic        out_uncorr;
  logic        clr_cnt;
  logic [3:0]  corr_cnt;
  logic [3:0]  uncorr_cnt;

  int tests = 0;
  int fails = 0;
  logic [3:0] corr_exp = 0;
  logic [3:0] uncorr_exp = 0;

  hamming_decoder #(.CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_syndrome(out_syndrome), .out_corr(out_corr), .out_uncorr(out_uncorr),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Check bits that make the word clean: XOR of the codeword positions of all set data bits.
  function automatic logic [6:0] enc(input logic [64:1] d);
    logic [6:0] par;
    int k;
    par = 0;
    k = 1;
    for (int p = 1; p <= 71; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) par = par ^ 7'(p);
        k++;
      end
    end
    return par;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Push one word through with out_ready high; returns what appeared at the output.
  task automatic run_word(input logic [64:1] d, input logic [6:0] p,
                          output logic [64:1] od, output logic [6:0] os,
                          output logic oc, output logic ou, output int lat);
    @(negedge clock);
    in_valid = 1'b1; in_d = d; in_p = p; out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    od = out_d; os = out_syndrome; oc = out_corr; ou = out_uncorr;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_d = '0; in_p = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_ctrl: out_valid=%0b in_ready=%0b corr=%0d uncorr=%0d, need 0 0 0 0",
               out_valid, in_ready, corr_cnt, uncorr_cnt);
    end
    tests++;
    if (out_d !== 64'h0 || out_syndrome !== 7'h0 || out_corr !== 1'b0 || out_uncorr !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: out_d=%h syn=%0d corr=%0b uncorr=%0b, need all 0",
               out_d, out_syndrome, out_corr, out_uncorr);
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_clean();
    logic [64:1] d, od; logic [6:0] os; logic oc, ou; int lat;
    d = 64'h0123_4567_89AB_CDEF;
    run_word(d, enc(d), od, os, oc, ou, lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL clean_latency: got %0d cycles, need 2", lat); end
    tests++;
    if (od !== d || os !== 7'd0 || oc !== 1'b0 || ou !== 1'b0) begin
      fails++;
      $display("FAIL clean_word: out_d=%h syn=%0d corr=%0b uncorr=%0b, need %h 0 0 0", od, os, oc, ou, d);
    end
    tests++;
    if (corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin
      fails++; $display("FAIL clean_counters: corr=%0d uncorr=%0d, need 0 0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_data_error();
    logic [64:1] d, bad, od; logic [6:0] os; logic oc, ou; int lat;
    d = 64'h0123_4567_89AB_CDEF;
    bad = d; bad[1] = ~bad[1];
    run_word(bad, enc(d), od, os, oc, ou, lat);
    corr_exp = sat_inc(corr_exp);
    tests++;
    if (od !== d || os !== 7'd3 || oc !== 1'b1 || ou !== 1'b0) begin
      fails++;
      $display("FAIL data_err: out_d=%h syn=%0d corr=%0b uncorr=%0b, need %h 3 1 0", od, os, oc, ou, d);
    end
    tests++;
    if (corr_cnt !== 4'd1) begin fails++; $display("FAIL data_err_cnt: corr_cnt=%0d, need 1", corr_cnt); end
  endtask

  task automatic test_check_error();
    logic [64:1] d, bad, want, od; logic [6:0] os, p; logic oc, ou; int lat;
    d = 64'h0123_4567_89AB_CDEF;
    p = enc(d); p[6] = ~p[6];
    run_word(d, p, od, os, oc, ou, lat);
    corr_exp = sat_inc(corr_exp);
    tests++;
    if (od !== d || os !== 7'd64 || oc !== 1'b1 || ou !== 1'b0) begin
      fails++;
      $display("FAIL check_err: out_d=%h syn=%0d corr=%0b uncorr=%0b, need %h 64 1 0", od, os, oc, ou, d);
    end
    // Positions 3 and 5 flipped: syndrome 6 points at in_d[3], which gets flipped too.
    bad = d; bad[1] = ~bad[1]; bad[2] = ~bad[2];
    want = bad; want[3] = ~want[3];
    run_word(bad, enc(d), od, os, oc, ou, lat);
    corr_exp = sat_inc(corr_exp);
    tests++;
    if (od !== want || os !== 7'd6 || oc !== 1'b1 || ou !== 1'b0) begin
      fails++;
      $display("FAIL double_err: out_d=%h syn=%0d corr=%0b uncorr=%0b, need %h 6 1 0", od, os, oc, ou, want);
    end
    bad = d; bad[1] = ~bad[1]; bad[2] = ~bad[2]; bad[3] = ~bad[3];
    run_word(bad, enc(d), od, os, oc, ou, lat);
    tests++;
    if (os !== 7'd0 || oc !== 1'b0 || od !== bad) begin
      fails++; $display("FAIL triple_err: syn=%0d corr=%0b out_d=%h, need 0 0 %h", os, oc, od, bad);
    end
    tests++;
    if (corr_cnt !== corr_exp) begin
      fails++; $display("FAIL check_err_cnt: corr_cnt=%0d, need %0d", corr_cnt, corr_exp);
    end
  endtask

  task automatic test_uncorr();
    logic [64:1] d, od; logic [6:0] os; logic oc, ou; int lat;
    d = 64'hFEDC_BA98_7654_3210;
    run_word(d, ~enc(d), od, os, oc, ou, lat);
    uncorr_exp = sat_inc(uncorr_exp);
    tests++;
    if (od !== d || os !== 7'd127 || oc !== 1'b0 || ou !== 1'b1) begin
      fails++;
      $display("FAIL uncorr: out_d=%h syn=%0d corr=%0b uncorr=%0b, need %h 127 0 1", od, os, oc, ou, d);
    end
    tests++;
    if (uncorr_cnt !== uncorr_exp || corr_cnt !== corr_exp) begin
      fails++;
      $display("FAIL uncorr_cnt: uncorr=%0d corr=%0d, need %0d %0d", uncorr_cnt, corr_cnt, uncorr_exp, corr_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [64:1] words [8];
    logic [64:1] prev_d; logic [6:0] prev_syn; logic prev_corr, prev_stall, exp_rdy;
    int tx, rx, hold, cyc, full_seen, bad_rdy, bad_stable;
    for (int i = 0; i < 8; i++) words[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 32'h0101_0F0F);
    tx = 0; rx = 0; hold = 0; cyc = 0; full_seen = 0; bad_rdy = 0; bad_stable = 0;
    prev_stall = 1'b0; prev_d = '0; prev_syn = '0; prev_corr = 1'b0;
    while (rx < 8 && cyc < 300) begin
      @(negedge clock);
      if (prev_stall && (out_valid !== 1'b1 || out_d !== prev_d ||
                         out_syndrome !== prev_syn || out_corr !== prev_corr))
        bad_stable++;
      if (cyc == 3) hold = 3;
      if (hold > 0) begin
        out_ready = 1'b0; hold--;
      end else if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0; hold = 2;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (tx < 8);
      if (tx < 8) begin
        in_d = words[tx];
        if (tx % 2 == 1) in_d[10 + tx] = ~in_d[10 + tx];
        in_p = enc(words[tx]);
      end
      #1;
      exp_rdy = !((tx - rx) >= 2 && !out_ready);
      if (in_ready !== exp_rdy) bad_rdy++;
      if (in_ready === 1'b0) full_seen++;
      if (out_valid && out_ready) begin
        tests++;
        if (rx >= 8 || out_d !== words[rx] || out_corr !== 1'(rx % 2)) begin
          fails++;
          $display("FAIL stream_word%0d: out_d=%h corr=%0b, need %h %0b",
                   rx, out_d, out_corr, words[rx % 8], 1'(rx % 2));
        end
        if (rx % 2 == 1) corr_exp = sat_inc(corr_exp);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_d; prev_syn = out_syndrome; prev_corr = out_corr;
      cyc++;
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if (rx !== 8 || tx !== 8) begin fails++; $display("FAIL stream_count: sent %0d got %0d, need 8 8", tx, rx); end
    tests++;
    if (bad_stable !== 0) begin fails++; $display("FAIL stream_stable: %0d unstable stalled cycles, need 0", bad_stable); end
    tests++;
    if (bad_rdy !== 0) begin fails++; $display("FAIL stream_in_ready: %0d wrong in_ready cycles, need 0", bad_rdy); end
    tests++;
    if (full_seen == 0) begin fails++; $display("FAIL stream_full: in_ready never 0 with both stages full"); end
    repeat (3) @(negedge clock);
    tests++;
    if (out_valid !== 1'b0 || corr_cnt !== corr_exp) begin
      fails++;
      $display("FAIL stream_tail: out_valid=%0b corr_cnt=%0d, need 0 %0d", out_valid, corr_cnt, corr_exp);
    end
  endtask

  task automatic test_saturation();
    logic [64:1] d, bad, od; logic [6:0] os; logic oc, ou; int lat;
    d = 64'h1357_9BDF_2468_ACE0;
    bad = d; bad[40] = ~bad[40];
    while (corr_exp != 4'hF) begin
      run_word(bad, enc(d), od, os, oc, ou, lat);
      corr_exp = sat_inc(corr_exp);
    end
    tests++;
    if (corr_cnt !== 4'd15) begin fails++; $display("FAIL sat_reach: corr_cnt=%0d, need 15", corr_cnt); end
    run_word(bad, enc(d), od, os, oc, ou, lat);
    tests++;
    if (corr_cnt !== 4'd15 || oc !== 1'b1) begin
      fails++; $display("FAIL sat_hold: corr_cnt=%0d corr=%0b, need 15 1", corr_cnt, oc);
    end
  endtask

  task automatic test_clear();
    logic [64:1] d, bad;
    d = 64'h0F0F_F0F0_0F0F_F0F0;
    bad = d; bad[64] = ~bad[64];
    @(negedge clock);
    in_valid = 1'b1; in_d = bad; in_p = enc(d); out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if (out_valid !== 1'b1 || out_corr !== 1'b1 || out_syndrome !== 7'd71 || out_d !== d) begin
      fails++;
      $display("FAIL clr_setup: out_valid=%0b corr=%0b syn=%0d out_d=%h, need 1 1 71 %h",
               out_valid, out_corr, out_syndrome, out_d, d);
    end
    out_ready = 1'b1; clr_cnt = 1'b1;
    @(negedge clock);
    clr_cnt = 1'b0;
    corr_exp = 0;
    tests++;
    if (corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clr_priority: corr=%0d uncorr=%0d out_valid=%0b, need 0 0 0", corr_cnt, uncorr_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_d = 64'h1111_2222_3333_4444; in_p = enc(64'h1111_2222_3333_4444);
    @(negedge clock);
    in_d = 64'h5555_6666_7777_8888; in_p = enc(64'h5555_6666_7777_8888);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL mid_inflight: out_valid=%0b in_ready=%0b, need 1 0", out_valid, in_ready);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || corr_cnt !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b corr=%0d, need 0 0 0", out_valid, in_ready, corr_cnt);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) stale++;
    end
    tests++;
    if (stale !== 0) begin fails++; $display("FAIL mid_stale: %0d cycles with out_valid=1, need 0", stale); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_error();
    test_check_error();
    test_uncorr();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
